// File: rtl/ftdi_cmd_rx_if.sv
// Handshake bundle for ftdi_cmd_rx: read-sequencer ACT/READY/DONE side,
// command valid/ready side toward the bus master, and drop reporting.
interface ftdi_cmd_rx_if;
    logic        oACT_RD_n;
    logic        iREADY_RD_n;
    logic        iDONE_RD_n;
    logic [7:0]  iRD_DATA;
    logic        oCMD_VALID;
    logic        iCMD_READY;
    logic        oCMD_WR;
    logic [15:0] oCMD_ADDR;
    logic [31:0] oCMD_WDATA;
    logic        oERR;
    logic [7:0]  oERR_CNT;

    modport master (
        output oACT_RD_n,
        input  iREADY_RD_n,
        input  iDONE_RD_n,
        input  iRD_DATA,
        output oCMD_VALID,
        input  iCMD_READY,
        output oCMD_WR,
        output oCMD_ADDR,
        output oCMD_WDATA,
        output oERR,
        output oERR_CNT
    );

    modport slave (
        input  oACT_RD_n,
        output iREADY_RD_n,
        output iDONE_RD_n,
        output iRD_DATA,
        input  oCMD_VALID,
        output iCMD_READY,
        input  oCMD_WR,
        input  oCMD_ADDR,
        input  oCMD_WDATA,
        input  oERR,
        input  oERR_CNT
    );
endinterface

// File: rtl/ftdi_cmd_rx.sv
// Byte-at-a-time packet parser behind the FT245R read sequencer; emits read/write
// commands on a valid/ready port. Define FTDI_CMD_CSUM_EN for a trailing XOR checksum.
module ftdi_cmd_rx #(
    parameter logic [7:0] CMD_WR = 8'h57,
    parameter logic [7:0] CMD_RD = 8'h52
) (
    input  logic          clk,
    input  logic          rst,
    ftdi_cmd_rx_if.master bus
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DECODE, S_ISSUE} state_t;

`ifdef FTDI_CMD_CSUM_EN
    localparam logic [2:0] LEN_RD = 3'd4;
    // An 8-byte write wraps the 3-bit counter back to zero
    localparam logic [2:0] LEN_WR = 3'd0;
`else
    localparam logic [2:0] LEN_RD = 3'd3;
    localparam logic [2:0] LEN_WR = 3'd7;
`endif
    localparam logic [2:0] LAST_RD_DATA = 3'd2;
    localparam logic [2:0] LAST_WR_DATA = 3'd6;

    state_t      state, state_next;
    logic        act_n, act_n_next;
    logic [2:0]  cnt, cnt_next;
    logic [7:0]  hdr, hdr_next;
    logic [47:0] payload, payload_next;
    logic        valid, valid_next;
    logic        wr, wr_next;
    logic [15:0] addr, addr_next;
    logic [31:0] wdata, wdata_next;
    logic        err, err_next;
    logic [7:0]  err_cnt, err_cnt_next;
    logic        is_wr, hdr_ok, pkt_done, csum_ok;

`ifdef FTDI_CMD_CSUM_EN
    logic [7:0]  acc, acc_next;
    assign csum_ok = (acc == 8'h00);
`else
    assign csum_ok = 1'b1;
`endif

    assign is_wr    = (hdr == CMD_WR);
    assign hdr_ok   = is_wr || (hdr == CMD_RD);
    assign pkt_done = (cnt == (is_wr ? LEN_WR : LEN_RD));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_REQ;
            act_n   <= 1'b1;
            cnt     <= 3'd0;
            hdr     <= 8'h00;
            payload <= 48'h0;
            valid   <= 1'b0;
            wr      <= 1'b0;
            addr    <= 16'h0;
            wdata   <= 32'h0;
            err     <= 1'b0;
            err_cnt <= 8'h00;
`ifdef FTDI_CMD_CSUM_EN
            acc     <= 8'h00;
`endif
        end else begin
            state   <= state_next;
            act_n   <= act_n_next;
            cnt     <= cnt_next;
            hdr     <= hdr_next;
            payload <= payload_next;
            valid   <= valid_next;
            wr      <= wr_next;
            addr    <= addr_next;
            wdata   <= wdata_next;
            err     <= err_next;
            err_cnt <= err_cnt_next;
`ifdef FTDI_CMD_CSUM_EN
            acc     <= acc_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        act_n_next   = 1'b1;
        cnt_next     = cnt;
        hdr_next     = hdr;
        payload_next = payload;
        valid_next   = valid;
        wr_next      = wr;
        addr_next    = addr;
        wdata_next   = wdata;
        err_next     = 1'b0;
        err_cnt_next = err_cnt;
`ifdef FTDI_CMD_CSUM_EN
        acc_next     = acc;
`endif
        case (state)
            S_REQ: begin
                if (!bus.iREADY_RD_n && !valid) begin
                    act_n_next = 1'b0;
                    state_next = S_WAIT;
                end
            end
            // READY may still read stale-low here, so only DONE matters
            S_WAIT: begin
                if (!bus.iDONE_RD_n) begin
                    cnt_next = cnt + 3'd1;
                    if (cnt == 3'd0)
                        hdr_next = bus.iRD_DATA;
                    else if (cnt <= (is_wr ? LAST_WR_DATA : LAST_RD_DATA))
                        payload_next = {payload[39:0], bus.iRD_DATA};
`ifdef FTDI_CMD_CSUM_EN
                    acc_next = acc ^ bus.iRD_DATA;
`endif
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!hdr_ok || (pkt_done && !csum_ok)) begin
                    err_next = 1'b1;
                    if (err_cnt != 8'hFF)
                        err_cnt_next = err_cnt + 8'd1;
                    cnt_next   = 3'd0;
`ifdef FTDI_CMD_CSUM_EN
                    acc_next   = 8'h00;
`endif
                    state_next = S_REQ;
                end else if (!pkt_done) begin
                    state_next = S_REQ;
                end else begin
                    valid_next = 1'b1;
                    wr_next    = is_wr;
                    addr_next  = is_wr ? payload[47:32] : payload[15:0];
                    wdata_next = is_wr ? payload[31:0] : 32'h0;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.iCMD_READY) begin
                    valid_next = 1'b0;
                    cnt_next   = 3'd0;
`ifdef FTDI_CMD_CSUM_EN
                    acc_next   = 8'h00;
`endif
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    assign bus.oACT_RD_n  = act_n;
    assign bus.oCMD_VALID = valid;
    assign bus.oCMD_WR    = wr;
    assign bus.oCMD_ADDR  = addr;
    assign bus.oCMD_WDATA = wdata;
    assign bus.oERR       = err;
    assign bus.oERR_CNT   = err_cnt;

endmodule

// File: tb/tb_ftdi_cmd_rx.sv
// Directed bench for ftdi_cmd_rx: behavioural FT245R read sequencer, vector table
// of packets with hand-computed results, plus backpressure/reset/saturation sequences.
module tb_ftdi_cmd_rx;

    typedef struct {
        logic [63:0] bytes;
        int          len;
        logic        issue;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          errs;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    ftdi_cmd_rx_if bus();

    ftdi_cmd_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  feed_mem [0:4095];
    logic [11:0] feed_wr = 12'd0;
    logic [11:0] feed_rd = 12'd0;
    int          stray_req = 0;
    logic [7:0]  stray_data = 8'h00;

    int   stray_done = 0;
    int   act_cnt = 0;
    int   done_cnt = 0;
    int   err_mon = 0;
    int   proto_bad = 0;
    int   ready_low_cyc = -1;
    int   first_act_cyc = -1;
    int   last_done_cyc = -1;
    logic seq_busy = 1'b0;
    int   seq_delay = 0;

    int n_vec = 0;
    int n_bad = 0;
    int exp_errcnt = 0;

    // Sequencer model: answers each ACT pulse with one DONE strobe two cycles later
    initial begin
        bus.iREADY_RD_n = 1'b1;
        bus.iDONE_RD_n  = 1'b1;
        bus.iRD_DATA    = 8'h00;
        forever begin
            @(negedge clk);
            bus.iDONE_RD_n = 1'b1;
            if (!rst) begin
                seq_busy        = 1'b0;
                feed_rd         = feed_wr;
                bus.iREADY_RD_n = 1'b1;
                continue;
            end
            if (!bus.oACT_RD_n) begin
                act_cnt++;
                if (first_act_cyc < 0) first_act_cyc = cyc;
                if (bus.oCMD_VALID || seq_busy || feed_rd == feed_wr) proto_bad++;
                seq_busy        = 1'b1;
                seq_delay       = 2;
                bus.iREADY_RD_n = 1'b1;
            end else if (seq_busy) begin
                seq_delay--;
                if (seq_delay == 0) begin
                    bus.iDONE_RD_n = 1'b0;
                    bus.iRD_DATA   = (feed_rd != feed_wr) ? feed_mem[feed_rd] : 8'h00;
                    if (feed_rd != feed_wr) feed_rd = feed_rd + 12'd1;
                    done_cnt++;
                    last_done_cyc = cyc;
                    seq_busy      = 1'b0;
                end
            end else if (stray_done != stray_req) begin
                bus.iDONE_RD_n = 1'b0;
                bus.iRD_DATA   = stray_data;
                stray_done++;
            end else begin
                bus.iREADY_RD_n = (feed_rd == feed_wr);
                if (!bus.iREADY_RD_n && ready_low_cyc < 0) ready_low_cyc = cyc;
            end
            if (bus.oERR) err_mon++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        feed_mem[feed_wr] = b;
        feed_wr = feed_wr + 12'd1;
    endtask

    task automatic push_vec(input vec_t v);
        logic [63:0] b;
        b = v.bytes;
        for (int i = 0; i < v.len; i++) begin
            push_byte(b[63:56]);
            b = b << 8;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        logic drained;
        drained = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (feed_rd == feed_wr && !seq_busy) begin
                drained = 1'b1;
                break;
            end
            tick();
        end
        check_output({name, ".drained"}, 64'(drained), 64'(1));
    endtask

    task automatic accept(input string name);
        bus.iCMD_READY = 1'b1;
        tick();
        bus.iCMD_READY = 1'b0;
        check_output({name, ".valid_after_ready"}, 64'(bus.oCMD_VALID), 64'(0));
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > 255) ? 255 : a + b;
    endfunction

    function automatic vec_t mk_read(input logic [15:0] a);
        vec_t v;
        v.bytes = {8'h52, a, 40'h0};
`ifdef FTDI_CMD_CSUM_EN
        v.bytes[39:32] = 8'h52 ^ a[15:8] ^ a[7:0];
        v.len = 4;
`else
        v.len = 3;
`endif
        v.issue = 1'b1;
        v.wr    = 1'b0;
        v.addr  = a;
        v.wdata = 32'h0;
        v.errs  = 0;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v, input string tag);
        int act0, err0, vcyc;
        act0 = act_cnt;
        err0 = err_mon;
        vcyc = -1;
        push_vec(v);
        wait_drain(tag, 600);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.oCMD_VALID && vcyc < 0) vcyc = cyc;
        end
        exp_errcnt = sat_add(exp_errcnt, v.errs);
        check_output({tag, ".valid"}, 64'(bus.oCMD_VALID), 64'(v.issue));
        if (v.issue) begin
            check_output({tag, ".wr"}, 64'(bus.oCMD_WR), 64'(v.wr));
            check_output({tag, ".addr"}, 64'(bus.oCMD_ADDR), 64'(v.addr));
            check_output({tag, ".wdata"}, 64'(bus.oCMD_WDATA), 64'(v.wdata));
            check_output({tag, ".valid_latency"}, 64'(vcyc - last_done_cyc), 64'(2));
            accept(tag);
        end
        check_output({tag, ".act_pulses"}, 64'(act_cnt - act0), 64'(v.len));
        check_output({tag, ".err_pulses"}, 64'(err_mon - err0), 64'(v.errs));
        check_output({tag, ".err_cnt"}, 64'(bus.oERR_CNT), 64'(exp_errcnt));
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, ".act_n"}, 64'(bus.oACT_RD_n), 64'(1));
        check_output({tag, ".valid"}, 64'(bus.oCMD_VALID), 64'(0));
        check_output({tag, ".wr"}, 64'(bus.oCMD_WR), 64'(0));
        check_output({tag, ".addr"}, 64'(bus.oCMD_ADDR), 64'(0));
        check_output({tag, ".wdata"}, 64'(bus.oCMD_WDATA), 64'(0));
        check_output({tag, ".err"}, 64'(bus.oERR), 64'(0));
        check_output({tag, ".err_cnt"}, 64'(bus.oERR_CNT), 64'(0));
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        vec_t v1, v2;
        int   act0, err0, d0, bad;
        logic reached;

`ifdef FTDI_CMD_CSUM_EN
        vecs.push_back('{64'h571234DEADBEEF53, 8, 1'b1, 1'b1, 16'h1234, 32'hDEADBEEF, 0});
        vecs.push_back('{64'h5200104200000000, 4, 1'b1, 1'b0, 16'h0010, 32'h0, 0});
        vecs.push_back('{64'h4152000153000000, 5, 1'b1, 1'b0, 16'h0001, 32'h0, 1});
        vecs.push_back('{64'h5200010000000000, 4, 1'b0, 1'b0, 16'h0, 32'h0, 1});
        vecs.push_back('{64'h5200015300000000, 4, 1'b1, 1'b0, 16'h0001, 32'h0, 0});
        vecs.push_back('{64'h52FFFF5200000000, 4, 1'b1, 1'b0, 16'hFFFF, 32'h0, 0});
        vecs.push_back('{64'h5700000000000057, 8, 1'b1, 1'b1, 16'h0000, 32'h0, 0});
        vecs.push_back('{64'h57FFFF0123456757, 8, 1'b1, 1'b1, 16'hFFFF, 32'h01234567, 0});
        vecs.push_back('{64'h571234DEADBEEF54, 8, 1'b0, 1'b0, 16'h0, 32'h0, 1});
        vecs.push_back('{64'h0000000000000000, 1, 1'b0, 1'b0, 16'h0, 32'h0, 1});
`else
        vecs.push_back('{64'h571234DEADBEEF00, 7, 1'b1, 1'b1, 16'h1234, 32'hDEADBEEF, 0});
        vecs.push_back('{64'h5200100000000000, 3, 1'b1, 1'b0, 16'h0010, 32'h0, 0});
        vecs.push_back('{64'h4152000100000000, 4, 1'b1, 1'b0, 16'h0001, 32'h0, 1});
        vecs.push_back('{64'h52FFFF0000000000, 3, 1'b1, 1'b0, 16'hFFFF, 32'h0, 0});
        vecs.push_back('{64'h5700000000000000, 7, 1'b1, 1'b1, 16'h0000, 32'h0, 0});
        vecs.push_back('{64'h57FFFF0123456700, 7, 1'b1, 1'b1, 16'hFFFF, 32'h01234567, 0});
        vecs.push_back('{64'h0000000000000000, 1, 1'b0, 1'b0, 16'h0, 32'h0, 1});
        vecs.push_back('{64'h7752ABCD00000000, 4, 1'b1, 1'b0, 16'hABCD, 32'h0, 1});
`endif

        bus.iCMD_READY = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++)
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        check_output("act_latency", 64'(first_act_cyc - ready_low_cyc), 64'(1));

        // Backpressure: command held 20 cycles while the next packet is already queued
        v1 = mk_read(16'h0010);
        v2 = mk_read(16'hABCD);
        push_vec(v1);
        wait_drain("bp", 600);
        repeat (4) tick();
        check_output("bp.valid", 64'(bus.oCMD_VALID), 64'(1));
        act0 = act_cnt;
        push_vec(v2);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.oCMD_VALID !== 1'b1 || bus.oCMD_WR !== 1'b0 ||
                bus.oCMD_ADDR !== 16'h0010 || bus.oCMD_WDATA !== 32'h0) bad++;
        end
        check_output("bp.stable_cycles_bad", 64'(bad), 64'(0));
        check_output("bp.act_during_hold", 64'(act_cnt - act0), 64'(0));
        accept("bp");
        wait_drain("bp2", 600);
        repeat (4) tick();
        check_output("bp2.valid", 64'(bus.oCMD_VALID), 64'(1));
        check_output("bp2.addr", 64'(bus.oCMD_ADDR), 64'(16'hABCD));
        check_output("bp2.wr", 64'(bus.oCMD_WR), 64'(0));
        accept("bp2");
        check_output("bp2.act_pulses", 64'(act_cnt - act0), 64'(v2.len));

        // Stray DONE and READY while idle must leave no trace
        act0 = act_cnt;
        err0 = err_mon;
        stray_data = 8'h57;
        stray_req++;
        bus.iCMD_READY = 1'b1;
        repeat (5) tick();
        bus.iCMD_READY = 1'b0;
        check_output("stray.valid", 64'(bus.oCMD_VALID), 64'(0));
        check_output("stray.act", 64'(act_cnt - act0), 64'(0));
        check_output("stray.err", 64'(err_mon - err0), 64'(0));
        apply_stimulus(mk_read(16'h0001), "after_stray");

        // 300 bad headers drive the drop counter into saturation
        err0 = err_mon;
        for (int i = 0; i < 300; i++) push_byte(8'h00);
        wait_drain("sat", 5000);
        repeat (4) tick();
        exp_errcnt = sat_add(exp_errcnt, 300);
        check_output("sat.err_pulses", 64'(err_mon - err0), 64'(300));
        check_output("sat.err_cnt", 64'(bus.oERR_CNT), 64'(8'hFF));

        // Reset after the third byte of a write discards the partial packet
        d0 = done_cnt;
        push_vec(vecs[0]);
        reached = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (done_cnt - d0 >= 3) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        check_output("midrst.reached_byte3", 64'(reached), 64'(1));
        rst = 1'b0;
        tick();
        check_reset_state("midrst");
        tick();
        rst = 1'b1;
        exp_errcnt = 0;
        tick();
        apply_stimulus(mk_read(16'hABCD), "after_rst");

        check_output("protocol_violations", 64'(proto_bad), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
